line_buf_rd_ctrl: RTL
=====================

// Module: line_buf_rd_ctrl
// PURPOSE
//  Downstream consumer of the video line-buffer FIFO (8-bit, 4096-deep, first-word-fall-through off,
//  read data valid 1 cycle after rd_en). Pops pixels from the FIFO once per frame_start, tolerates the
//  1-cycle read latency via a 2-entry output buffer, and emits a valid/ready pixel stream with
//  start-of-frame (m_user) and end-of-line (m_last) markers for the display/processing stage.
// PARAMETERS
//  DATA_WIDTH  8     pixel width; equals FIFO rd_data width
//  H_ACTIVE    1024  pixels per line (1..4096)
//  V_ACTIVE    768   lines per frame (>=1)
//  X_W / Y_W / N_W   localparams: clog2(H_ACTIVE), clog2(V_ACTIVE), clog2(H_ACTIVE*V_ACTIVE+1)
// PORTS
//  clk           in   1           single clock; same clock as FIFO rd_clk
//  rst_n         in   1           asynchronous active-low reset
//  frame_start   in   1           1-cycle pulse: begin reading one frame
//  fifo_rd_en    out  1           FIFO read strobe
//  fifo_rd_data  in   DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
//  fifo_empty    in   1           FIFO empty flag
//  m_valid       out  1           output pixel valid
//  m_ready       in   1           downstream accept
//  m_data        out  DATA_WIDTH  pixel
//  m_user        out  1           first pixel of frame (x=0,y=0)
//  m_last        out  1           last pixel of line (x=H_ACTIVE-1)
//  busy          out  1           state != IDLE
//  frame_done    out  1           1-cycle pulse: last pixel of frame accepted
//  frame_err     out  1           1-cycle pulse: frame_start received while busy
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; buffer empty; fifo_rd_en=0, m_valid=0, m_data=0, m_user=0,
//   m_last=0, busy=0, frame_done=0, frame_err=0.
//  FSM: IDLE --frame_start--> RUN (issued=0, x=y=0) ; RUN --issued reaches H_ACTIVE*V_ACTIVE--> DRAIN ;
//   DRAIN --last pixel popped--> IDLE (frame_done=1 same edge). frame_start in RUN/DRAIN: ignored,
//   frame_err pulses next cycle; counters unaffected.
//  Read issue (combinational): fifo_rd_en = (state==RUN) & !fifo_empty & (issued < H_ACTIVE*V_ACTIVE)
//   & (occ + inflight - pop < 2); pop = m_valid & m_ready; inflight = fifo_rd_en registered.
//   Guarantees occ never exceeds 2; full throughput of 1 pixel/cycle when m_ready held high.
//  Latency: frame_start at edge N -> fifo_rd_en high in cycle N+1 (if !fifo_empty) -> m_valid in N+3.
//  Buffer: 2-entry FIFO; write when inflight=1 (captures fifo_rd_data); simultaneous push+pop allowed
//   at occ=1 or 2. m_valid = (occ!=0); m_data held stable while m_valid & !m_ready.
//  Position: x,y advance only on pop; x wraps H_ACTIVE-1 -> 0 with y+1; m_user/m_last are decoded
//   from x,y and are stable with m_data. After final pop x=y=0.
//  fifo_empty mid-line: reads stall, m_valid drops when buffer drains; no pixel lost or duplicated.
//  Reset mid-frame: immediate return to IDLE, buffer discarded; FIFO contents untouched (owner's job).
// STRUCTURE
//  Shared include line_buf_defs.vh: FSM state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), counter
//   width macros. Sub-module line_rd_obuf: 2-entry synchronous buffer (push, pop, din, dout,
//   occ[1:0]); controller owns FSM, issue logic, x/y/issued counters.
// TESTING (bench models FIFO with 1-cycle read latency, data = decrementing 8-bit count from 8'hFF)
//  1 Reset release, no frame_start, FIFO full -> fifo_rd_en and m_valid stay 0, busy=0.
//  2 H_ACTIVE=4,V_ACTIVE=2, FIFO preloaded, m_ready=1 -> 8 pixels FF..F8 on consecutive cycles,
//    m_user on FF only, m_last on FC and F8, frame_done one cycle after F8 accepted, busy falls.
//  3 Same, m_ready toggled 1/0 every cycle -> identical pixel sequence, m_data stable while stalled,
//    occ never >2, exactly 8 fifo_rd_en pulses.
//  4 fifo_empty forced high for 5 cycles after 3rd pixel -> m_valid gap, sequence continues FC.. intact.
//  5 frame_start pulsed again mid-frame -> frame_err pulse, output sequence/count unchanged.
//  6 rst_n low for 1 cycle after 5th pixel -> all outputs 0 immediately; next frame_start restarts at x=y=0.

Source files
------------

// File: rtl/line_buf_rd_ctrl_pkg.sv
// Shared types and width helpers for the line-buffer read controller.
package line_buf_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int OBUF_DEPTH = 2;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buf_rd_ctrl_if.sv
// Valid/ready pixel stream with start-of-frame and end-of-line markers.
interface line_buf_rd_ctrl_if #(parameter int DATA_WIDTH = 8);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_user;
  logic                  m_last;

  modport master (output m_valid, m_data, m_user, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_user, m_last, output m_ready);

endinterface

// File: rtl/line_buf_rd_ctrl_obuf.sv
// Two-entry synchronous buffer absorbing the one-cycle FIFO read latency.
module line_buf_rd_ctrl_obuf
  import line_buf_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage is cleared on reset so the idle stream presents zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/line_buf_rd_ctrl.sv
// Pops one frame from the line-buffer FIFO per frame_start and streams it out
// with frame/line markers, tolerating the FIFO's one-cycle read latency.
module line_buf_rd_ctrl
  import line_buf_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  line_buf_rd_ctrl_if.master     pix,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int X_W   = cw(H_ACTIVE);
  localparam int Y_W   = cw(V_ACTIVE);
  localparam int N_W   = cw(TOTAL + 1);

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [N_W-1:0] N_TOTAL = N_W'(TOTAL);
  localparam logic [N_W-1:0] N_LAST  = N_W'(TOTAL - 1);

  state_t                state;
  state_t                next_state;
  logic [N_W-1:0]        issued;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic                  inflight;
  logic                  pop;
  logic                  last_pop;
  logic                  room;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] obuf_dout;

  assign pop      = pix.m_valid & pix.m_ready;
  assign last_pop = pop & (x == X_LAST) & (y == Y_LAST);
  // Buffered plus in-flight pixels, net of this cycle's pop, must stay below two.
  assign room     = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_start) next_state = RUN;
      RUN:     if (fifo_rd_en && (issued == N_LAST)) next_state = DRAIN;
      DRAIN:   if (last_pop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    fifo_rd_en = (state == RUN) && !fifo_empty && (issued < N_TOTAL) && room;
  end

  // Position only moves on accepted pixels, so markers stay aligned with m_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued     <= '0;
      x          <= '0;
      y          <= '0;
      inflight   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= (state == DRAIN) && last_pop;
      frame_err  <= frame_start && (state != IDLE);
      if ((state == IDLE) && frame_start) begin
        issued <= '0;
        x      <= '0;
        y      <= '0;
      end else begin
        if (fifo_rd_en) begin
          issued <= issued + N_W'(1);
        end
        if (pop) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
          end else begin
            x <= x + X_W'(1);
          end
        end
      end
    end
  end

  line_buf_rd_ctrl_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_rd_data),
    .dout  (obuf_dout),
    .occ   (occ)
  );

  assign pix.m_valid = (occ != 2'd0);
  assign pix.m_data  = obuf_dout;
  assign pix.m_user  = pix.m_valid && (x == '0) && (y == '0);
  assign pix.m_last  = pix.m_valid && (x == X_LAST);

endmodule
